// File: rtl/ifu_imem_slave.sv
// ifu_imem_slave: AXI4-Lite read-only instruction memory with fixed latency; IFU_IMEM_RAND_DELAY_EN adds LFSR jitter
module ifu_imem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h80000000,
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 1,
  parameter string       MEM_FILE  = "",
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_araddr,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  input  logic        ifu_rready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [5:0] cnt, cnt_n, lat;
  logic [31:0] off;
  logic hs, decerr, slverr;
  logic [31:0] mem [DEPTH];
  assign ifu_arready = state == IDLE && !rst;
  assign ifu_rvalid = state == RESP;
  assign hs = ifu_arvalid && ifu_arready;
  assign off = ifu_araddr - BASE_ADDR;
  assign decerr = |off[31:AW+2];
  assign slverr = |off[1:0];
`ifdef IFU_IMEM_RAND_DELAY_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk)
    if (rst) lfsr <= LFSR_SEED;
    else if (hs) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign lat = 6'(LATENCY) + {1'b0, lfsr[4:0]};
`else
  assign lat = 6'(LATENCY);
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (hs) begin
        state_n = lat == 6'd0 ? RESP : WAIT;
        cnt_n = lat;
      end
      WAIT: begin
        cnt_n = cnt - 6'd1;
        state_n = cnt == 6'd1 ? RESP : WAIT;
      end
      RESP: state_n = ifu_rready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ifu_rdata <= '0;
      ifu_rresp <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (hs) begin
        ifu_rdata <= (decerr || slverr) ? 32'd0 : mem[off[AW+1:2]];
        ifu_rresp <= decerr ? 2'b11 : slverr ? 2'b10 : 2'b00;
      end
    end
  end
endmodule
